pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage CPU. It generates the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and handles load-use bubbles and memory-busy stalls. It detects and commits exceptions, external interrupts and exception returns at the MEM boundary, and drives the PC redirect. It also owns the control registers (status, interrupt mask, exception PC/vector/code), which are read and written by CR instructions.

---
 rtl/pipe_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage CPU.
//   Generates stall/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB,
//   inserts load-use bubbles and commits exceptions, interrupts and
//   exception returns at the MEM boundary, driving the fetch redirect.
//   Owns the control registers (STATUS, INT_MASK, IRQ, EXP_CODE,
//   EXP_VECTOR, EPC), accessed by WRCR instructions and cr_addr reads.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, CR6 is a free-running if_stall cycle counter and CR7 counts
//   committed exceptions plus interrupts. Both are cleared by WRCR to their
//   index. When undefined, CR6/CR7 read 0 and no counter logic exists.
//
// Ports:
//   cpu_clk, cpu_rstn          clock, asynchronous active-low reset
//   irq[IRQ_W]                 asynchronous external interrupt levels
//   ld_hazard, mem_busy        load-use hazard, data bus not complete
//   mem_en, mem_pc, mem_exp_code, mem_ctrl_op
//                              MEM-stage instruction valid/PC/exception/CR op
//   cr_addr, cr_wdata, cr_rdata
//                              control register index, write and read data
//   exe_mode, int_en           current privilege mode, global interrupt enable
//   *_stall, *_flush           per-pipeline-register hold / bubble controls
//   new_pc_en, new_pc          fetch redirect

module pipe_ctrl #(
    parameter int unsigned IRQ_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [29:0] VEC_RESET   = 30'h0
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic [IRQ_W-1:0] irq,
    input  logic             ld_hazard,
    input  logic             mem_busy,
    input  logic             mem_en,
    input  logic [29:0]      mem_pc,
    input  logic [2:0]       mem_exp_code,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       cr_addr,
    input  logic [31:0]      cr_wdata,
    output logic [31:0]      cr_rdata,
    output logic             exe_mode,
    output logic             int_en,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             new_pc_en,
    output logic [29:0]      new_pc
);

    localparam logic [1:0] OP_WRCR   = 2'd1;
    localparam logic [1:0] OP_EXRT   = 2'd2;

    localparam logic [2:0] CODE_IRQ  = 3'd1;
    localparam logic [2:0] CODE_PRIV = 3'd6;

    localparam logic [4:0] CR_STATUS = 5'd0;
    localparam logic [4:0] CR_MASK   = 5'd1;
    localparam logic [4:0] CR_IRQ    = 5'd2;
    localparam logic [4:0] CR_CODE   = 5'd3;
    localparam logic [4:0] CR_VECTOR = 5'd4;
    localparam logic [4:0] CR_EPC    = 5'd5;
`ifdef PIPE_CTRL_PERF_EN
    localparam logic [4:0] CR_PSTALL = 5'd6;
    localparam logic [4:0] CR_PEXC   = 5'd7;
`endif

    // SETTLE covers the one cycle after a redirect while the refetch begins
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                         state_q, state_d;
    logic                               exe_mode_q, exe_mode_d;
    logic                               int_en_q, int_en_d;
    logic                               pre_exe_mode_q, pre_exe_mode_d;
    logic                               pre_int_en_q, pre_int_en_d;
    logic [IRQ_W-1:0]                   int_mask_q, int_mask_d;
    logic [29:0]                        epc_q, epc_d;
    logic [2:0]                         exp_code_q, exp_code_d;
    logic [29:0]                        exp_vector_q, exp_vector_d;
    logic [SYNC_STAGES-1:0][IRQ_W-1:0]  irq_sync_q, irq_sync_d;

    logic [IRQ_W-1:0] irq_sync;
    logic [IRQ_W-1:0] irq_p;
    logic             commit;
    logic             int_req;
    logic             take_exc;
    logic             take_exrt;
    logic             cr_wr;
    logic [2:0]       exc_code;
    logic             flush_req;
    logic             redirect;

    assign irq_sync = irq_sync_q[SYNC_STAGES-1];

    // Commit decision at the MEM boundary, highest priority first
    always_comb begin
        commit    = mem_en & ~mem_busy;
        irq_p     = irq_sync & ~int_mask_q;
        int_req   = int_en_q & (|irq_p) & (state_q == ST_RUN);
        take_exc  = 1'b0;
        take_exrt = 1'b0;
        cr_wr     = 1'b0;
        exc_code  = 3'd0;
        if (commit) begin
            if (mem_exp_code != 3'd0) begin
                take_exc = 1'b1;
                exc_code = mem_exp_code;
            end else if (mem_ctrl_op == OP_EXRT) begin
                take_exrt = 1'b1;
            end else if (int_req) begin
                take_exc = 1'b1;
                exc_code = CODE_IRQ;
            end else if (mem_ctrl_op == OP_WRCR) begin
                // CR writes from user mode become a privilege violation
                if (exe_mode_q) begin
                    cr_wr = 1'b1;
                end else begin
                    take_exc = 1'b1;
                    exc_code = CODE_PRIV;
                end
            end
        end
        flush_req = take_exc | take_exrt;
        // Redirect and flushes are held low while reset is asserted
        redirect  = flush_req & cpu_rstn;
    end

    // Pipeline controls; a flush overrides a stall on the same register
    always_comb begin
        if_flush  = redirect;
        id_flush  = redirect | (ld_hazard & ~mem_busy & cpu_rstn);
        ex_flush  = redirect;
        mem_flush = redirect;
        if_stall  = (ld_hazard | mem_busy) & ~if_flush;
        id_stall  = mem_busy & ~id_flush;
        ex_stall  = mem_busy & ~ex_flush;
        mem_stall = mem_busy & ~mem_flush;
        new_pc_en = redirect;
        new_pc    = 30'h0;
        if (redirect) begin
            new_pc = take_exc ? exp_vector_q : epc_q;
        end
    end

    assign exe_mode = exe_mode_q;
    assign int_en   = int_en_q;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_exc_q, perf_exc_d;

    // A WRCR clear takes precedence over a same-cycle increment
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_exc_d   = perf_exc_q;
        if (cr_wr && (cr_addr == CR_PSTALL)) begin
            perf_stall_d = 32'h0;
        end else if (if_stall) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (cr_wr && (cr_addr == CR_PEXC)) begin
            perf_exc_d = 32'h0;
        end else if (take_exc) begin
            perf_exc_d = perf_exc_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            perf_stall_q <= 32'h0;
            perf_exc_q   <= 32'h0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_exc_q   <= perf_exc_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control register read
    // ------------------------------------------------------------------
    always_comb begin
        cr_rdata = 32'h0;
        case (cr_addr)
            CR_STATUS: cr_rdata = {28'h0, pre_int_en_q, pre_exe_mode_q,
                                   int_en_q, exe_mode_q};
            CR_MASK:   cr_rdata = 32'(int_mask_q);
            CR_IRQ:    cr_rdata = 32'(irq_sync);
            CR_CODE:   cr_rdata = {29'h0, exp_code_q};
            CR_VECTOR: cr_rdata = {exp_vector_q, 2'b00};
            CR_EPC:    cr_rdata = {epc_q, 2'b00};
`ifdef PIPE_CTRL_PERF_EN
            CR_PSTALL: cr_rdata = perf_stall_q;
            CR_PEXC:   cr_rdata = perf_exc_q;
`endif
            default:   cr_rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        exe_mode_d     = exe_mode_q;
        int_en_d       = int_en_q;
        pre_exe_mode_d = pre_exe_mode_q;
        pre_int_en_d   = pre_int_en_q;
        int_mask_d     = int_mask_q;
        epc_d          = epc_q;
        exp_code_d     = exp_code_q;
        exp_vector_d   = exp_vector_q;

        // irq enters at stage 0 and becomes visible after SYNC_STAGES edges
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], irq};

        // Any redirect (re)enters SETTLE; otherwise SETTLE lasts one cycle
        case (state_q)
            ST_RUN:    state_d = flush_req ? ST_SETTLE : ST_RUN;
            ST_SETTLE: state_d = flush_req ? ST_SETTLE : ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        if (take_exc) begin
            epc_d          = mem_pc;
            exp_code_d     = exc_code;
            pre_exe_mode_d = exe_mode_q;
            pre_int_en_d   = int_en_q;
            exe_mode_d     = 1'b1;
            int_en_d       = 1'b0;
        end else if (take_exrt) begin
            exe_mode_d = pre_exe_mode_q;
            int_en_d   = pre_int_en_q;
        end else if (cr_wr) begin
            case (cr_addr)
                CR_STATUS: begin
                    exe_mode_d     = cr_wdata[0];
                    int_en_d       = cr_wdata[1];
                    pre_exe_mode_d = cr_wdata[2];
                    pre_int_en_d   = cr_wdata[3];
                end
                CR_MASK:   int_mask_d   = cr_wdata[IRQ_W-1:0];
                CR_VECTOR: exp_vector_d = cr_wdata[31:2];
                CR_EPC:    epc_d        = cr_wdata[31:2];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q        <= ST_RUN;
            exe_mode_q     <= 1'b1;
            int_en_q       <= 1'b0;
            pre_exe_mode_q <= 1'b0;
            pre_int_en_q   <= 1'b0;
            int_mask_q     <= '1;
            epc_q          <= 30'h0;
            exp_code_q     <= 3'h0;
            exp_vector_q   <= VEC_RESET;
            irq_sync_q     <= '0;
        end else begin
            state_q        <= state_d;
            exe_mode_q     <= exe_mode_d;
            int_en_q       <= int_en_d;
            pre_exe_mode_q <= pre_exe_mode_d;
            pre_int_en_q   <= pre_int_en_d;
            int_mask_q     <= int_mask_d;
            epc_q          <= epc_d;
            exp_code_q     <= exp_code_d;
            exp_vector_q   <= exp_vector_d;
            irq_sync_q     <= irq_sync_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random checks of pipe_ctrl against a
// behavioural model of the controller's architectural state.

module tb_pipe_ctrl;

    localparam int unsigned IRQ_W = 8;
    localparam int unsigned SYNC  = 2;

    logic              cpu_clk = 1'b0;
    logic              cpu_rstn;
    logic [IRQ_W-1:0]  irq;
    logic              ld_hazard, mem_busy, mem_en;
    logic [29:0]       mem_pc;
    logic [2:0]        mem_exp_code;
    logic [1:0]        mem_ctrl_op;
    logic [4:0]        cr_addr;
    logic [31:0]       cr_wdata, cr_rdata;
    logic              exe_mode, int_en;
    logic              if_stall, id_stall, ex_stall, mem_stall;
    logic              if_flush, id_flush, ex_flush, mem_flush;
    logic              new_pc_en;
    logic [29:0]       new_pc;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.IRQ_W(IRQ_W), .SYNC_STAGES(SYNC), .VEC_RESET(30'h0)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .irq(irq),
        .ld_hazard(ld_hazard), .mem_busy(mem_busy), .mem_en(mem_en),
        .mem_pc(mem_pc), .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op),
        .cr_addr(cr_addr), .cr_wdata(cr_wdata), .cr_rdata(cr_rdata),
        .exe_mode(exe_mode), .int_en(int_en),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc_en(new_pc_en), .new_pc(new_pc)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Architectural model
    bit          m_mode, m_ie, m_pmode, m_pie, m_settle;
    logic [7:0]  m_mask;
    logic [29:0] m_epc, m_vec;
    logic [2:0]  m_code;
    logic [7:0]  m_irq_hist[$];
    logic [31:0] m_stall_cnt, m_exc_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 1'b1; m_ie = 1'b0; m_pmode = 1'b0; m_pie = 1'b0; m_settle = 1'b0;
        m_mask = 8'hFF; m_epc = '0; m_vec = '0; m_code = '0;
        m_stall_cnt = '0; m_exc_cnt = '0;
        m_irq_hist.delete();
        for (int i = 0; i < int'(SYNC); i++) m_irq_hist.push_back(8'h0);
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic [7:0] sync_v);
        case (a)
            5'd0: return {28'h0, m_pie, m_pmode, m_ie, m_mode};
            5'd1: return {24'h0, m_mask};
            5'd2: return {24'h0, sync_v};
            5'd3: return {29'h0, m_code};
            5'd4: return {m_vec, 2'b00};
            5'd5: return {m_epc, 2'b00};
`ifdef PIPE_CTRL_PERF_EN
            5'd6: return m_stall_cnt;
            5'd7: return m_exc_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Check all outputs mid-cycle against the model, then advance one edge
    task automatic step();
        logic [7:0]  sync_v;
        logic        commit, ireq, exc, exrt, wr, flush, stall_if;
        logic [2:0]  c;
        logic [29:0] pc_exp;
        @(negedge cpu_clk);
        sync_v = m_irq_hist[0];
        commit = mem_en & ~mem_busy;
        ireq   = m_ie & (|(sync_v & ~m_mask)) & ~m_settle;
        exc = 1'b0; exrt = 1'b0; wr = 1'b0; c = 3'd0;
        if (commit) begin
            if (mem_exp_code != 3'd0)      begin exc = 1'b1; c = mem_exp_code; end
            else if (mem_ctrl_op == 2'd2)  exrt = 1'b1;
            else if (ireq)                 begin exc = 1'b1; c = 3'd1; end
            else if (mem_ctrl_op == 2'd1) begin
                if (m_mode) wr = 1'b1;
                else begin exc = 1'b1; c = 3'd6; end
            end
        end
        flush    = exc | exrt;
        stall_if = (ld_hazard | mem_busy) & ~flush;
        pc_exp   = exc ? m_vec : (exrt ? m_epc : 30'h0);
        chk("flush", {if_flush, id_flush, ex_flush, mem_flush},
            {flush, flush | (ld_hazard & ~mem_busy), flush, flush});
        chk("stall", {if_stall, id_stall, ex_stall, mem_stall},
            {stall_if, mem_busy & ~flush & ~(ld_hazard & ~mem_busy),
             mem_busy & ~flush, mem_busy & ~flush});
        chk("new_pc_en", new_pc_en, flush);
        chk("new_pc", new_pc, pc_exp);
        chk("cr_rdata", cr_rdata, model_rd(cr_addr, sync_v));
        chk("mode_ie", {exe_mode, int_en}, {m_mode, m_ie});
        @(posedge cpu_clk);
        if (exc) begin
            m_epc = mem_pc; m_code = c; m_pmode = m_mode; m_pie = m_ie;
            m_mode = 1'b1; m_ie = 1'b0;
        end else if (exrt) begin
            m_mode = m_pmode; m_ie = m_pie;
        end else if (wr) begin
            case (cr_addr)
                5'd0: {m_pie, m_pmode, m_ie, m_mode} = cr_wdata[3:0];
                5'd1: m_mask = cr_wdata[7:0];
                5'd4: m_vec  = cr_wdata[31:2];
                5'd5: m_epc  = cr_wdata[31:2];
                default: ;
            endcase
        end
        if (wr && cr_addr == 5'd6) m_stall_cnt = '0;
        else if (stall_if)         m_stall_cnt = m_stall_cnt + 32'd1;
        if (wr && cr_addr == 5'd7) m_exc_cnt = '0;
        else if (exc)              m_exc_cnt = m_exc_cnt + 32'd1;
        m_settle = flush;
        m_irq_hist.push_back(irq);
        void'(m_irq_hist.pop_front());
        #1;
    endtask

    task automatic idle();
        ld_hazard = 1'b0; mem_busy = 1'b0; mem_en = 1'b0; mem_pc = 30'h0;
        mem_exp_code = 3'd0; mem_ctrl_op = 2'd0; cr_wdata = 32'h0;
    endtask

    task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
        idle();
        mem_en = 1'b1; mem_ctrl_op = 2'd1; cr_addr = a; cr_wdata = d;
        step();
        idle();
    endtask

    initial begin
        // Reset with commit-triggering inputs: outputs must stay quiet
        cpu_rstn = 1'b0; irq = '0; cr_addr = 5'd0;
        idle();
        ld_hazard = 1'b1; mem_en = 1'b1; mem_pc = 30'h40; mem_exp_code = 3'd3;
        repeat (2) @(posedge cpu_clk);
        #2;
        chk("rst_flush", {if_flush, id_flush, ex_flush, mem_flush}, 4'h0);
        chk("rst_new_pc_en", new_pc_en, 1'b0);
        chk("rst_new_pc", new_pc, 30'h0);
        chk("rst_mode_ie", {exe_mode, int_en}, 2'b10);
        @(posedge cpu_clk);
        #1;
        cpu_rstn = 1'b1;
        idle();
        model_reset();

        cr_addr = 5'd0; #1 chk("cr0_reset", cr_rdata, 32'h1);
        cr_addr = 5'd1; #1 chk("cr1_reset", cr_rdata, 32'hFF);
        step();

        // Load-use bubble, then load-use under a memory stall
        ld_hazard = 1'b1;
        #1 chk("lu_if_stall", if_stall, 1'b1);
        chk("lu_id_flush", id_flush, 1'b1);
        chk("lu_other_stall", {id_stall, ex_stall, mem_stall}, 3'b000);
        step();
        ld_hazard = 1'b1; mem_busy = 1'b1;
        #1 chk("lubusy_id_flush", id_flush, 1'b0);
        chk("lubusy_stalls", {if_stall, id_stall, ex_stall, mem_stall}, 4'hF);
        step();
        idle();

        // Synchronous exception to EXP_VECTOR=0x100
        wrcr(5'd4, 32'h400);
        mem_en = 1'b1; mem_pc = 30'h40; mem_exp_code = 3'd3;
        #1 chk("exc_flush", {if_flush, id_flush, ex_flush, mem_flush}, 4'hF);
        chk("exc_new_pc", new_pc, 30'h100);
        step();
        idle();
        cr_addr = 5'd5; #1 chk("exc_epc", cr_rdata, 32'h100);
        cr_addr = 5'd3; #1 chk("exc_code", cr_rdata, 32'h3);
        cr_addr = 5'd0; #1 chk("exc_status", cr_rdata, 32'h5);
        step();

        // Interrupt on irq[0], eligible after SYNC cycles
        wrcr(5'd1, 32'hFE);
        wrcr(5'd0, 32'h3);
        irq = 8'h01;
        mem_en = 1'b1; mem_pc = 30'h40;
        for (int k = 0; k <= int'(SYNC); k++) begin
            #1 chk("irq_latency", new_pc_en, (k == int'(SYNC)) ? 1'b1 : 1'b0);
            step();
        end
        idle();
        cr_addr = 5'd3; #1 chk("irq_code", cr_rdata, 32'h1);
        cr_addr = 5'd5; #1 chk("irq_epc", cr_rdata, 32'h100);
        step();

        // EXRT with irq still pending: blocked in SETTLE, taken next cycle
        mem_en = 1'b1; mem_ctrl_op = 2'd2;
        #1 chk("exrt_new_pc", new_pc, 30'h40);
        step();
        idle(); mem_en = 1'b1; mem_pc = 30'h44;
        #1 chk("settle_int_en", int_en, 1'b1);
        chk("settle_no_irq", new_pc_en, 1'b0);
        step();
        #1 chk("post_settle_irq", new_pc_en, 1'b1);
        step();
        idle();

        // Re-enable, mask irq[0]: no interrupt commit
        mem_en = 1'b1; mem_ctrl_op = 2'd2;
        step();
        wrcr(5'd1, 32'hFF);
        for (int k = 0; k < 4; k++) begin
            mem_en = 1'b1; mem_pc = 30'h50;
            #1 chk("masked_no_irq", new_pc_en, 1'b0);
            step();
        end
        idle(); irq = '0;

        // User-mode WRCR is a privilege violation
        wrcr(5'd0, 32'h0);
        mem_en = 1'b1; mem_ctrl_op = 2'd1; cr_addr = 5'd1; cr_wdata = 32'h55;
        #1 chk("priv_flush", {if_flush, id_flush, ex_flush, mem_flush}, 4'hF);
        chk("priv_new_pc", new_pc, 30'h100);
        step();
        idle();
        cr_addr = 5'd1; #1 chk("priv_cr1", cr_rdata, 32'hFF);
        cr_addr = 5'd3; #1 chk("priv_code", cr_rdata, 32'h6);
        step();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) irq = 8'($urandom);
            ld_hazard    = ($urandom_range(0, 5) == 0);
            mem_busy     = ($urandom_range(0, 4) == 0);
            mem_en       = ($urandom_range(0, 9) < 6);
            mem_pc       = 30'($urandom);
            mem_exp_code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mem_ctrl_op  = 2'($urandom_range(0, 3));
            cr_addr      = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom);
            cr_wdata     = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
